// File: rtl/mem_access_stage.sv
// +------------------------------------------------------------------------+
// | Module   : mem_access_stage                                            |
// | Purpose  : RV64 memory-access pipeline stage. Accepts one instruction  |
// |            from execute, issues load/store traffic over a valid/ready  |
// |            request and a valid-only response channel, aligns and      |
// |            sign/zero-extends load data, and hands the result plus      |
// |            forwarded control to write-back with a one-cycle wb_valid.  |
// | Option   : MEM_MISALIGN_CHECK_EN - when defined, misaligned half/word/ |
// |            double accesses skip memory and report misaligned=1.        |
// | Ports    : clk, reset (sync, active-high)                              |
// |            execute side : mem_enable, alu_result, store_data,          |
// |                           control_signals_in                           |
// |            memory side  : dmem_req_valid/ready, dmem_we, dmem_addr,    |
// |                           dmem_wdata, dmem_wstrb, dmem_resp_valid,     |
// |                           dmem_resp_data                               |
// |            write-back   : alu_result_out, loaded_data,                 |
// |                           control_signals_out, wb_valid, misaligned    |
// |            pipeline     : stage_busy (execute stalls while high)       |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
`default_nettype none

package mem_access_pkg;
  typedef struct packed {
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [4:0]  dest_reg;
    logic [63:0] pc;
  } control_signals_struct;
endpackage

module mem_access_stage
  import mem_access_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  mem_enable,
  input  logic [63:0]           alu_result,
  input  logic [63:0]           store_data,
  input  control_signals_struct control_signals_in,
  output logic                  dmem_req_valid,
  input  logic                  dmem_req_ready,
  output logic                  dmem_we,
  output logic [63:0]           dmem_addr,
  output logic [63:0]           dmem_wdata,
  output logic [7:0]            dmem_wstrb,
  input  logic                  dmem_resp_valid,
  input  logic [63:0]           dmem_resp_data,
  output logic [63:0]           alu_result_out,
  output logic [63:0]           loaded_data,
  output control_signals_struct control_signals_out,
  output logic                  wb_valid,
  output logic                  stage_busy,
  output logic                  misaligned
);

  localparam logic [6:0] C_OP_LOAD  = 7'b0000011;
  localparam logic [6:0] C_OP_STORE = 7'b0100011;
  localparam logic [6:0] C_OP_LUI   = 7'b0110111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t                state_q, state_d;
  // Instruction latched at acceptance; drives the request while it is in flight.
  logic [63:0]           alu_q, alu_d;
  logic [63:0]           store_q, store_d;
  control_signals_struct ctrl_q, ctrl_d;
  // Write-back facing registers; only change on entry to DONE.
  logic [63:0]           alu_out_q, alu_out_d;
  logic [63:0]           load_q, load_d;
  control_signals_struct ctrl_out_q, ctrl_out_d;
  logic                  mis_q, mis_d;

  logic                  w_in_mem;
  logic                  w_in_misalign;
  logic                  w_is_load;
  logic                  w_is_store;
  logic                  w_req;
  logic [2:0]            w_off;
  logic [63:0]           w_lane;
  logic [63:0]           w_load_ext;
  logic [7:0]            w_strb_base;

  assign w_in_mem   = (control_signals_in.opcode == C_OP_LOAD) ||
                      (control_signals_in.opcode == C_OP_STORE);
  assign w_is_load  = (ctrl_q.opcode == C_OP_LOAD);
  assign w_is_store = (ctrl_q.opcode == C_OP_STORE);
  assign w_off      = alu_q[2:0];
  assign w_req      = (state_q == S_REQ);

`ifdef MEM_MISALIGN_CHECK_EN
  // Natural alignment by access size (funct3[1:0]); bytes are never misaligned.
  function automatic logic misaligned_fn(input logic [1:0] size, input logic [2:0] off);
    case (size)
      2'b01:   misaligned_fn = off[0];
      2'b10:   misaligned_fn = |off[1:0];
      2'b11:   misaligned_fn = |off;
      default: misaligned_fn = 1'b0;
    endcase
  endfunction
  assign w_in_misalign = w_in_mem &&
                         misaligned_fn(control_signals_in.funct3[1:0], alu_result[2:0]);
`else
  assign w_in_misalign = 1'b0;
`endif

  // Right shift zero-fills, so bytes past the doubleword boundary read as 0.
  assign w_lane = dmem_resp_data >> {w_off, 3'b000};

  always_comb begin
    w_load_ext = w_lane;
    case (ctrl_q.funct3)
      3'b000:  w_load_ext = {{56{w_lane[7]}},  w_lane[7:0]};
      3'b001:  w_load_ext = {{48{w_lane[15]}}, w_lane[15:0]};
      3'b010:  w_load_ext = {{32{w_lane[31]}}, w_lane[31:0]};
      3'b100:  w_load_ext = {56'd0, w_lane[7:0]};
      3'b101:  w_load_ext = {48'd0, w_lane[15:0]};
      3'b110:  w_load_ext = {32'd0, w_lane[31:0]};
      default: w_load_ext = w_lane;
    endcase
  end

  always_comb begin
    w_strb_base = 8'h01;
    case (ctrl_q.funct3[1:0])
      2'b00:   w_strb_base = 8'h01;
      2'b01:   w_strb_base = 8'h03;
      2'b10:   w_strb_base = 8'h0F;
      default: w_strb_base = 8'hFF;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      alu_q      <= '0;
      store_q    <= '0;
      ctrl_q     <= '0;
      alu_out_q  <= '0;
      load_q     <= '0;
      ctrl_out_q <= '0;
      mis_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      alu_q      <= alu_d;
      store_q    <= store_d;
      ctrl_q     <= ctrl_d;
      alu_out_q  <= alu_out_d;
      load_q     <= load_d;
      ctrl_out_q <= ctrl_out_d;
      mis_q      <= mis_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    alu_d      = alu_q;
    store_d    = store_q;
    ctrl_d     = ctrl_q;
    alu_out_d  = alu_out_q;
    load_d     = load_q;
    ctrl_out_d = ctrl_out_q;
    mis_d      = mis_q;
    case (state_q)
      S_IDLE: begin
        if (mem_enable) begin
          alu_d   = alu_result;
          store_d = store_data;
          ctrl_d  = control_signals_in;
          if (w_in_mem && !w_in_misalign) begin
            state_d = S_REQ;
          end else begin
            // No memory traffic: publish results straight from the inputs.
            state_d    = S_DONE;
            alu_out_d  = alu_result;
            ctrl_out_d = control_signals_in;
            mis_d      = w_in_misalign;
            load_d     = (control_signals_in.opcode == C_OP_LUI && !w_in_misalign)
                         ? alu_result : 64'd0;
            if (w_in_misalign) begin
              ctrl_out_d.dest_reg = 5'd0;
            end
          end
        end
      end
      S_REQ: begin
        if (dmem_req_ready) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (dmem_resp_valid) begin
          state_d    = S_DONE;
          alu_out_d  = alu_q;
          ctrl_out_d = ctrl_q;
          mis_d      = 1'b0;
          load_d     = w_is_load ? w_load_ext : 64'd0;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Request fields are driven only in REQ, so they read 0 in every other state.
  assign dmem_req_valid      = w_req;
  assign dmem_we             = w_req && w_is_store;
  assign dmem_addr           = w_req ? {alu_q[63:3], 3'b000} : 64'd0;
  assign dmem_wdata          = (w_req && w_is_store) ? (store_q << {w_off, 3'b000}) : 64'd0;
  assign dmem_wstrb          = (w_req && w_is_store) ? (w_strb_base << w_off) : 8'h00;

  assign alu_result_out      = alu_out_q;
  assign loaded_data         = load_q;
  assign control_signals_out = ctrl_out_q;
  assign misaligned          = mis_q;
  assign wb_valid            = (state_q == S_DONE);
  assign stage_busy          = (state_q != S_IDLE);

endmodule

`default_nettype wire
